// File: rtl/tqvp_uart_pkg.sv
// Shared UART constants and types: FIFO defaults plus the frame widths used by tqvp_uart_rx.
package tqvp_uart_pkg;

    localparam int PAYLOAD_BITS_DEFAULT = 8;
    localparam int DEPTH_LOG2_DEFAULT   = 2;

    localparam int UART_START_BITS = 1;
    localparam int UART_STOP_BITS  = 1;
    localparam int UART_CLK_DIV_W  = 16;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } uart_rx_state_t;

    function automatic int uart_frame_bits(input int payload_bits);
        return UART_START_BITS + payload_bits + UART_STOP_BITS;
    endfunction

endpackage

// File: rtl/tqvp_uart_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, contents never reset.
module tqvp_uart_fifo_mem #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    // NOTE: storage has no reset branch; the read side masks stale words with the FIFO level instead.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tqvp_uart_rx_fifo.sv
// First-word-fall-through receive FIFO between the UART receiver and the CPU.
// Define TQVP_UART_RX_OVERRUN_DROP_EN to drop bytes when full and flag overrun instead of back-pressuring.
module tqvp_uart_rx_fifo
    import tqvp_uart_pkg::*;
#(
    parameter int PAYLOAD_BITS = PAYLOAD_BITS_DEFAULT,
    parameter int DEPTH_LOG2   = DEPTH_LOG2_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_rx_valid,
    input  logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_read,
    input  logic                    flush,
    input  logic                    rd_en,
    output logic                    rd_valid,
    output logic [PAYLOAD_BITS-1:0] rd_data,
    output logic                    full,
    output logic [DEPTH_LOG2:0]     level,
    output logic                    overrun,
    input  logic                    overrun_clr
);

    localparam logic [DEPTH_LOG2:0] DEPTH_LVL = (DEPTH_LOG2 + 1)'(2 ** DEPTH_LOG2);
    localparam logic [DEPTH_LOG2:0] PTR_ONE   = (DEPTH_LOG2 + 1)'(1);

    // Pointers carry one extra bit so a full FIFO is distinguishable from an empty one.
    logic [DEPTH_LOG2:0]     wr_ptr;
    logic [DEPTH_LOG2:0]     rd_ptr;
    logic                    read_q;
    logic                    push;
    logic                    pop;
    logic [PAYLOAD_BITS-1:0] mem_rdata;

    assign level    = wr_ptr - rd_ptr;
    assign full     = (level == DEPTH_LVL);
    assign rd_valid = (level != '0);
    assign pop      = rd_en && rd_valid;
    assign rd_data  = rd_valid ? mem_rdata : '0;

`ifdef TQVP_UART_RX_OVERRUN_DROP_EN
    logic drop;

    // read_q keeps the pulse from repeating while the receiver is still lowering valid.
    assign uart_rx_read = !reset && uart_rx_valid && !read_q;
    assign push         = uart_rx_read && (!full || pop);
    assign drop         = uart_rx_read && full && !pop;

    always_ff @(posedge clk) begin
        if (reset)            overrun <= 1'b0;
        else if (drop)        overrun <= 1'b1;
        else if (overrun_clr) overrun <= 1'b0;
    end
`else
    // Full with a same-cycle rd_en still accepts, since that rd_en is guaranteed to pop.
    assign uart_rx_read = !reset && uart_rx_valid && !read_q && (!full || rd_en);
    assign push         = uart_rx_read;
    assign overrun      = 1'b0;

    logic unused_clr;
    assign unused_clr = overrun_clr;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            read_q <= 1'b0;
        end else begin
            read_q <= uart_rx_read;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    tqvp_uart_fifo_mem #(
        .WIDTH  (PAYLOAD_BITS),
        .ADDR_W (DEPTH_LOG2)
    ) u_mem (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr_ptr[DEPTH_LOG2-1:0]),
        .wdata (uart_rx_data),
        .raddr (rd_ptr[DEPTH_LOG2-1:0]),
        .rdata (mem_rdata)
    );

endmodule

// File: doc/tqvp_uart_rx_fifo.md
TQVP_UART_RX_FIFO -- requirements
Module: tqvp_uart_rx_fifo

Interface
REQ-001 SHALL have parameter PAYLOAD_BITS, default 8, data width per byte.
REQ-002 SHALL have parameter DEPTH_LOG2, default 2, FIFO depth = 2**DEPTH_LOG2 (4).
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- uart_rx_valid  in  1  byte held by UART receiver
- uart_rx_data  in  PAYLOAD_BITS  byte from UART receiver
- uart_rx_read  out  1  pop pulse to UART receiver
- flush  in  1  discard all entries
- rd_en  in  1  CPU pops head entry
- rd_valid  out  1  FIFO non-empty
- rd_data  out  PAYLOAD_BITS  head entry
- full  out  1  FIFO holds 2**DEPTH_LOG2 entries
- level  out  DEPTH_LOG2+1  entry count
- overrun  out  1  sticky byte-dropped flag
- overrun_clr  in  1  clears overrun

Function
REQ-005 SHALL be first-word-fall-through: rd_data = head entry when rd_valid=1, zero when empty.
REQ-006 SHALL drive uart_rx_read combinationally, so the push occurs in the same cycle the pulse is issued.
REQ-007 SHALL push when uart_rx_read=1 and uart_rx_valid=1; written data is visible on rd_data the next cycle when the FIFO was empty (latency 1).
REQ-008 SHALL pop on rd_en=1 with rd_valid=1; rd_en with FIFO empty is ignored without error.
REQ-009 SHALL, on simultaneous push and pop, keep level unchanged, including when full.
REQ-010 SHALL wrap read and write pointers modulo depth; level = write count minus read count in DEPTH_LOG2+1 bits.
REQ-011 SHALL assert full exactly when level == 2**DEPTH_LOG2 and rd_valid exactly when level != 0.
REQ-012 SHALL, on flush, zero both pointers and level next cycle; flush overrides same-cycle push and pop; overrun is unaffected.
REQ-013 SHALL, on overrun_clr, clear overrun; a same-cycle overrun set wins over clear.
REQ-014 SHALL never issue uart_rx_read in two consecutive cycles, since the receiver drops valid one cycle after read.

Reset
REQ-015 SHALL, on reset, set level=0, both pointers=0, overrun=0, rd_valid=0, full=0, rd_data=0, uart_rx_read=0.
REQ-016 SHALL leave storage array contents unreset.
REQ-017 SHALL give reset priority over flush, push and pop.

Configuration
REQ-018 SHALL support macro TQVP_UART_RX_OVERRUN_DROP_EN.
REQ-019 SHALL, with the macro defined:
- uart_rx_read = uart_rx_valid (subject to REQ-014)
- a byte arriving when full with no same-cycle pop is discarded
- the discard sets overrun
REQ-020 SHALL, with the macro undefined:
- uart_rx_read = uart_rx_valid && (!full || rd_en)
- the receiver is back-pressured and holds its byte
- overrun is tied to 0

Structure
REQ-021 SHALL take PAYLOAD_BITS and DEPTH_LOG2 defaults from shared package tqvp_uart_pkg, which also holds the UART width constants used by tqvp_uart_rx.
REQ-022 SHALL place storage in one sub-module, tqvp_uart_fifo_mem: 1 write port, 1 asynchronous read port, no reset.

Verification
REQ-023 Push 0x41, 0x42, 0x43 with one uart_rx_valid level held per byte -> each gives exactly one uart_rx_read pulse; level 3; CPU pops return 0x41, 0x42, 0x43 in order.
REQ-024 Fill 4 entries, then push 0x55 with no pop -> drop macro defined: 0x55 lost, overrun=1, level 4. Macro undefined: uart_rx_read stays 0 until rd_en, then 0x55 is accepted in the pop cycle with level staying 4.
REQ-025 Full FIFO, rd_en and push of 0x99 in the same cycle -> level stays 4; 0x99 is read as the fourth pop.
REQ-026 Pointer wrap: push and pop 10 bytes 0x00..0x09 interleaved -> data returned in order; level never exceeds 4.
REQ-027 Level 3, flush with a same-cycle push -> next cycle level 0, rd_valid 0, rd_data 0x00; overrun unchanged.
REQ-028 Reset asserted mid-operation with level 2 and overrun 1 -> next cycle all outputs at REQ-015 values.
